// File: rtl/ann_io_pkg.sv
// Shared types and elaboration-time helpers for the ANN host/accelerator I/O sequencer.
// Counts are derived from the top-level parameters at elaboration only.
package ann_io_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_LOAD,
      S_NODES,
      S_LEAVES,
      S_QUERIES,
      S_GAP,
      S_START,
      S_RUN,
      S_SEND,
      S_DRAIN,
      S_DONE,
      S_ERR
   } state_t;

   function automatic int node_word_count(input int num_nodes);
      return 2 * num_nodes;
   endfunction

   function automatic int leaf_word_count(input int num_leaves, input int leaf_words);
      return num_leaves * leaf_words;
   endfunction

   function automatic int query_word_count(input int row_size, input int col_size,
                                           input int patch_words);
      return row_size * col_size * patch_words;
   endfunction

   // Column blocks covering one half-row of queries.
   function automatic int x_blocks(input int row_size, input int blocking);
      return (row_size / 2 + blocking - 1) / blocking;
   endfunction

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   function automatic int ctr_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

   localparam int DEF_NODE_WORDS  = node_word_count(63);
   localparam int DEF_LEAF_WORDS  = leaf_word_count(64, 48);
   localparam int DEF_QUERY_WORDS = query_word_count(26, 19, 5);
   localparam int DEF_XB          = x_blocks(26, 4);

endpackage

// File: rtl/ann_out_addr_gen.sv
// Result address walker for the accelerator drain order (px > x > y > xi).
// Addresses are built from running bases; column positions past the half-row are skipped.
module ann_out_addr_gen
   import ann_io_pkg::*;
#(
   parameter int ROW_SIZE   = 26,
   parameter int COL_SIZE   = 19,
   parameter int BLOCKING   = 4,
   parameter int ADDR_WIDTH = 9
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   input  logic                  adv,
   output logic [ADDR_WIDTH-1:0] addr,
   output logic                  last
);

   localparam int XB   = x_blocks(ROW_SIZE, BLOCKING);
   localparam int XW   = ctr_width(XB - 1);
   localparam int YW   = ctr_width(COL_SIZE - 1);
   localparam int XIW  = ctr_width(BLOCKING - 1);

   localparam logic [XW-1:0]         X_LAST  = XW'(XB - 1);
   localparam logic [YW-1:0]         Y_LAST  = YW'(COL_SIZE - 1);
   localparam logic [XIW-1:0]        XI_LAST = XIW'(BLOCKING - 1);
   localparam logic [ADDR_WIDTH-1:0] HALF_A  = ADDR_WIDTH'(ROW_SIZE / 2);
   localparam logic [ADDR_WIDTH-1:0] ROW_A   = ADDR_WIDTH'(ROW_SIZE);
   localparam logic [ADDR_WIDTH-1:0] BLK_A   = ADDR_WIDTH'(BLOCKING);

   logic                  px;
   logic [XW-1:0]         x;
   logic [YW-1:0]         y;
   logic [XIW-1:0]        xi;
   logic [ADDR_WIDTH-1:0] px_base;
   logic [ADDR_WIDTH-1:0] row_base;
   logic [ADDR_WIDTH-1:0] col_base;
   logic [ADDR_WIDTH-1:0] col;
   logic                  block_end;
   logic                  y_end;
   logic                  x_end;

   assign col       = col_base + ADDR_WIDTH'(xi);
   // The block ends early when the next column would fall off the half-row.
   assign block_end = (xi == XI_LAST) || ((col + ADDR_WIDTH'(1)) >= HALF_A);
   assign y_end     = (y == Y_LAST);
   assign x_end     = (x == X_LAST);
   assign last      = px & x_end & y_end & block_end;
   assign addr      = px_base + row_base + col;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         px       <= 1'b0;
         x        <= '0;
         y        <= '0;
         xi       <= '0;
         px_base  <= '0;
         row_base <= '0;
         col_base <= '0;
      end else if (clr) begin
         px       <= 1'b0;
         x        <= '0;
         y        <= '0;
         xi       <= '0;
         px_base  <= '0;
         row_base <= '0;
         col_base <= '0;
      end else if (adv) begin
         if (!block_end) begin
            xi <= xi + XIW'(1);
         end else begin
            xi <= '0;
            if (!y_end) begin
               y        <= y + YW'(1);
               row_base <= row_base + ROW_A;
            end else begin
               y        <= '0;
               row_base <= '0;
               if (!x_end) begin
                  x        <= x + XW'(1);
                  col_base <= col_base + BLK_A;
               end else begin
                  x        <= '0;
                  col_base <= '0;
                  px       <= ~px;
                  px_base  <= px ? '0 : HALF_A;
               end
            end
         end
      end
   end

endmodule

// File: rtl/ann_io_sequencer.sv
// Host-side sequencer for the KD-tree ANN accelerator: streams tree and query words in,
// kicks the accelerator, and drains best-match indices out as raster-addressed results.
module ann_io_sequencer
   import ann_io_pkg::*;
#(
   parameter int DATA_WIDTH  = 11,
   parameter int NUM_NODES   = 63,
   parameter int NUM_LEAVES  = 64,
   parameter int LEAF_WORDS  = 48,
   parameter int PATCH_WORDS = 5,
   parameter int ROW_SIZE    = 26,
   parameter int COL_SIZE    = 19,
   parameter int BLOCKING    = 4,
   parameter int GAP_CYCLES  = 10,
   parameter int TIMEOUT     = 2**20,
   parameter int ADDR_WIDTH  = $clog2(ROW_SIZE * COL_SIZE)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  go,
   input  logic                  reuse_tree,
   input  logic                  abort,
   output logic                  busy,
   output logic                  img_done,
   output logic                  error,
   input  logic                  src_valid,
   output logic                  src_ready,
   input  logic [DATA_WIDTH-1:0] src_data,
   output logic                  load_kdtree,
   output logic                  in_fifo_wenq,
   output logic [DATA_WIDTH-1:0] in_fifo_wdata,
   input  logic                  in_fifo_wfull_n,
   output logic                  fsm_start,
   input  logic                  fsm_done,
   output logic                  send_best_arr,
   output logic                  out_fifo_deq,
   input  logic [DATA_WIDTH-1:0] out_fifo_rdata,
   input  logic                  out_fifo_rempty_n,
   output logic                  res_valid,
   output logic [ADDR_WIDTH-1:0] res_addr,
   output logic [DATA_WIDTH-1:0] res_data
);

   localparam int N_NODE  = node_word_count(NUM_NODES);
   localparam int N_LEAF  = leaf_word_count(NUM_LEAVES, LEAF_WORDS);
   localparam int N_QUERY = query_word_count(ROW_SIZE, COL_SIZE, PATCH_WORDS);
   localparam int WC_W    = ctr_width(max3(N_NODE, N_LEAF, N_QUERY) - 1);
   localparam int GC_W    = ctr_width(GAP_CYCLES - 1);
   localparam int RC_W    = ctr_width(TIMEOUT - 1);

   localparam logic [WC_W-1:0] NODE_LAST  = WC_W'(N_NODE - 1);
   localparam logic [WC_W-1:0] LEAF_LAST  = WC_W'(N_LEAF - 1);
   localparam logic [WC_W-1:0] QUERY_LAST = WC_W'(N_QUERY - 1);
   localparam logic [GC_W-1:0] GAP_LAST   = GC_W'(GAP_CYCLES - 1);
   localparam logic [RC_W-1:0] RUN_LAST   = RC_W'(TIMEOUT - 1);

   state_t                state;
   state_t                next_phase;
   logic [WC_W-1:0]       word_cnt;
   logic [WC_W-1:0]       phase_last;
   logic [GC_W-1:0]       gap_cnt;
   logic [RC_W-1:0]       run_cnt;
   logic                  in_stream;
   logic                  xfer;
   logic                  deq;
   logic                  img_done_q;
   logic                  res_valid_q;
   logic                  gen_clr;
   logic [ADDR_WIDTH-1:0] gen_addr;
   logic                  gen_last;

   // Input handshake is combinational so a word moves in the cycle it is offered.
   assign in_stream     = (state == S_NODES) || (state == S_LEAVES) || (state == S_QUERIES);
   assign xfer          = in_stream & src_valid & in_fifo_wfull_n & ~abort;
   assign src_ready     = xfer;
   assign in_fifo_wenq  = xfer;
   assign in_fifo_wdata = src_data;

   assign deq           = (state == S_DRAIN) & out_fifo_rempty_n & ~abort;
   assign out_fifo_deq  = deq;

   assign busy          = !((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));
   assign load_kdtree   = (state == S_LOAD) & ~abort;
   assign fsm_start     = (state == S_START) & ~abort;
   assign send_best_arr = (state == S_SEND) & ~abort;
   assign img_done      = img_done_q & ~abort;
   assign res_valid     = res_valid_q & ~abort;

   assign gen_clr       = (state != S_DRAIN) | abort;

   always_comb begin
      phase_last = QUERY_LAST;
      next_phase = S_GAP;
      case (state)
         S_NODES: begin
            phase_last = NODE_LAST;
            next_phase = S_LEAVES;
         end
         S_LEAVES: begin
            phase_last = LEAF_LAST;
            next_phase = S_QUERIES;
         end
         default: ;
      endcase
   end

   ann_out_addr_gen #(
      .ROW_SIZE   (ROW_SIZE),
      .COL_SIZE   (COL_SIZE),
      .BLOCKING   (BLOCKING),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_addr_gen (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (gen_clr),
      .adv   (deq),
      .addr  (gen_addr),
      .last  (gen_last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         word_cnt    <= '0;
         gap_cnt     <= '0;
         run_cnt     <= '0;
         error       <= 1'b0;
         img_done_q  <= 1'b0;
         res_valid_q <= 1'b0;
         res_addr    <= '0;
         res_data    <= '0;
      end else begin
         img_done_q  <= 1'b0;
         res_valid_q <= 1'b0;
         if (abort) begin
            state    <= S_IDLE;
            word_cnt <= '0;
            gap_cnt  <= '0;
            run_cnt  <= '0;
            error    <= 1'b0;
         end else begin
            case (state)
               S_IDLE, S_DONE, S_ERR: begin
                  if (go) begin
                     word_cnt <= '0;
                     state    <= reuse_tree ? S_QUERIES : S_LOAD;
                  end
               end
               S_LOAD: state <= S_NODES;
               S_NODES, S_LEAVES, S_QUERIES: begin
                  if (xfer) begin
                     if (word_cnt == phase_last) begin
                        word_cnt <= '0;
                        state    <= next_phase;
                     end else begin
                        word_cnt <= word_cnt + WC_W'(1);
                     end
                  end
               end
               S_GAP: begin
                  if (gap_cnt == GAP_LAST) begin
                     gap_cnt <= '0;
                     state   <= S_START;
                  end else begin
                     gap_cnt <= gap_cnt + GC_W'(1);
                  end
               end
               S_START: begin
                  run_cnt <= '0;
                  state   <= S_RUN;
               end
               // Accelerator completion wins over a timeout landing in the same cycle.
               S_RUN: begin
                  if (fsm_done) begin
                     run_cnt <= '0;
                     state   <= S_SEND;
                  end else if (run_cnt == RUN_LAST) begin
                     run_cnt <= '0;
                     error   <= 1'b1;
                     state   <= S_ERR;
                  end else begin
                     run_cnt <= run_cnt + RC_W'(1);
                  end
               end
               S_SEND: state <= S_DRAIN;
               S_DRAIN: begin
                  if (deq) begin
                     res_valid_q <= 1'b1;
                     res_data    <= out_fifo_rdata;
                     res_addr    <= gen_addr;
                     if (gen_last) begin
                        img_done_q <= 1'b1;
                        state      <= S_DONE;
                     end
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ann_io_sequencer.sv
// Directed/randomized bench for ann_io_sequencer with a behavioural stream and drain-order model.
module tb_ann_io_sequencer;

   localparam int DW       = 11;
   localparam int AW       = 9;
   localparam int ROW      = 26;
   localparam int COL      = 19;
   localparam int BLK      = 4;
   localparam int GAP      = 10;
   localparam int TMO      = 100;
   localparam int N_TREE   = 126 + 3072;
   localparam int N_QUERY  = 2470;
   localparam int N_ALL    = N_TREE + N_QUERY;
   localparam int N_RES    = ROW * COL;
   localparam int FIFO_N   = N_RES + 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          go = 1'b0;
   logic          reuse_tree = 1'b0;
   logic          abort = 1'b0;
   logic          busy, img_done, error;
   logic          src_valid = 1'b0;
   logic          src_ready;
   logic [DW-1:0] src_data = '0;
   logic          load_kdtree, in_fifo_wenq;
   logic [DW-1:0] in_fifo_wdata;
   logic          in_fifo_wfull_n = 1'b1;
   logic          fsm_start;
   logic          fsm_done = 1'b0;
   logic          send_best_arr, out_fifo_deq;
   logic [DW-1:0] out_fifo_rdata = '0;
   logic          out_fifo_rempty_n = 1'b0;
   logic          res_valid;
   logic [AW-1:0] res_addr;
   logic [DW-1:0] res_data;

   ann_io_sequencer #(.TIMEOUT(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .go(go), .reuse_tree(reuse_tree), .abort(abort),
      .busy(busy), .img_done(img_done), .error(error),
      .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
      .load_kdtree(load_kdtree), .in_fifo_wenq(in_fifo_wenq), .in_fifo_wdata(in_fifo_wdata),
      .in_fifo_wfull_n(in_fifo_wfull_n), .fsm_start(fsm_start), .fsm_done(fsm_done),
      .send_best_arr(send_best_arr), .out_fifo_deq(out_fifo_deq),
      .out_fifo_rdata(out_fifo_rdata), .out_fifo_rempty_n(out_fifo_rempty_n),
      .res_valid(res_valid), .res_addr(res_addr), .res_data(res_data)
   );

   always #5 clk = ~clk;

   int            n_tests = 0;
   int            n_fail  = 0;
   logic [DW-1:0] stream [N_ALL];
   logic [DW-1:0] fifo_words [FIFO_N];
   int            exp_addr [$];
   int            n_load, n_wenq, n_start, n_send, n_res, fifo_idx, src_idx;
   int            start_cyc, last_wenq_cyc, n_words;
   bit            done_seen, prev_deq;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Runs one image; returns early on done, or on the requested stop points.
   task automatic run_image(input bit reuse, input bit rnd, input int done_delay,
                            input int stop_wenq, input int stop_res, input int budget);
      bit xfer, deq;
      n_words = reuse ? N_QUERY : N_ALL;
      for (int i = 0; i < N_ALL; i++) stream[i] = DW'($urandom);
      for (int i = 0; i < FIFO_N; i++) fifo_words[i] = DW'($urandom);
      n_load = 0; n_wenq = 0; n_start = 0; n_send = 0; n_res = 0;
      fifo_idx = 0; src_idx = 0; start_cyc = 0; last_wenq_cyc = 0;
      done_seen = 1'b0; prev_deq = 1'b0;
      @(posedge clk); #1;
      go = 1'b1; reuse_tree = reuse; src_valid = 1'b1; src_data = stream[0];
      in_fifo_wfull_n = 1'b1; out_fifo_rempty_n = 1'b1; out_fifo_rdata = fifo_words[0];
      fsm_done = 1'b0;
      for (int cyc = 0; cyc < budget; cyc++) begin
         @(negedge clk);
         xfer = src_valid & src_ready;
         deq  = out_fifo_deq;
         if (load_kdtree) n_load++;
         if (in_fifo_wenq) begin
            chk("wenq_while_full", in_fifo_wfull_n, 1);
            if (n_wenq == 0) chk("load_before_words", n_load, reuse ? 0 : 1);
            chk("wenq_in_range", (n_wenq < n_words), 1);
            if (n_wenq < n_words) chk("wdata_order", in_fifo_wdata, stream[n_wenq]);
            n_wenq++;
            last_wenq_cyc = cyc;
         end
         if (fsm_start) begin
            n_start++;
            start_cyc = cyc;
            chk("gap_to_start", cyc - last_wenq_cyc, GAP + 1);
         end
         if (send_best_arr) n_send++;
         if (res_valid || prev_deq) chk("res_latency", res_valid, prev_deq);
         if (res_valid) begin
            chk("res_addr", res_addr, exp_addr[n_res]);
            chk("res_data", res_data, fifo_words[n_res]);
            n_res++;
         end
         prev_deq = deq;
         if (img_done) begin
            done_seen = 1'b1;
            chk("done_after_results", n_res, N_RES);
            chk("no_extra_deq", fifo_idx, N_RES);
         end
         if (done_seen || (stop_wenq > 0 && n_wenq >= stop_wenq) ||
             (stop_res > 0 && n_res >= stop_res) || (done_delay < 0 && n_start > 0))
            return;
         @(posedge clk); #1;
         go = 1'b0;
         if (xfer) src_idx++;
         src_data = (src_idx < n_words) ? stream[src_idx] : '0;
         if (deq) fifo_idx++;
         out_fifo_rdata    = (fifo_idx < FIFO_N) ? fifo_words[fifo_idx] : '0;
         in_fifo_wfull_n   = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         out_fifo_rempty_n = (fifo_idx < FIFO_N) && (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
         fsm_done = (n_start > 0) && (done_delay >= 0) && (cyc == start_cyc + done_delay);
      end
      chk("image_budget", done_seen, 1);
   endtask

   task automatic check_complete(input bit reuse);
      chk("done_seen", done_seen, 1);
      chk("load_pulses", n_load, reuse ? 0 : 1);
      chk("wenq_total", n_wenq, reuse ? N_QUERY : N_ALL);
      chk("start_pulses", n_start, 1);
      chk("send_pulses", n_send, 1);
      chk("result_total", n_res, N_RES);
      @(negedge clk);
      chk("busy_after_done", busy, 0);
      chk("img_done_one_cycle", img_done, 0);
   endtask

   initial begin
      for (int px = 0; px < 2; px++)
         for (int x = 0; x < (ROW / 2 + BLK - 1) / BLK; x++)
            for (int y = 0; y < COL; y++)
               for (int xi = 0; xi < BLK; xi++)
                  if (x * BLK + xi < ROW / 2)
                     exp_addr.push_back(px * (ROW / 2) + y * ROW + x * BLK + xi);

      // Reset state, with live-looking inputs to expose any leakage.
      src_valid = 1'b1; out_fifo_rempty_n = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_error", error, 0);
      chk("rst_img_done", img_done, 0);
      chk("rst_src_ready", src_ready, 0);
      chk("rst_wenq", in_fifo_wenq, 0);
      chk("rst_load", load_kdtree, 0);
      chk("rst_start", fsm_start, 0);
      chk("rst_send", send_best_arr, 0);
      chk("rst_deq", out_fifo_deq, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_addr", res_addr, 0);
      chk("rst_res_data", res_data, 0);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("idle_src_ready", src_ready, 0);

      // Full image with tree load, free-flowing FIFOs.
      run_image(1'b0, 1'b0, 3, 0, 0, 8000);
      check_complete(1'b0);

      // Back-pressure on both FIFOs.
      run_image(1'b0, 1'b1, 5, 0, 0, 16000);
      check_complete(1'b0);

      // Reused tree: only query words stream in.
      run_image(1'b1, 1'b0, 2, 0, 0, 4000);
      check_complete(1'b1);

      // Accelerator never finishes: timeout into ERR, then abort.
      run_image(1'b1, 1'b0, -1, 0, 0, 4000);
      chk("timeout_start_seen", n_start, 1);
      for (int i = 1; i <= TMO + 1; i++) begin
         @(posedge clk); #1;
         @(negedge clk);
         if (i == TMO) begin
            chk("run_error_pre", error, 0);
            chk("run_busy_pre", busy, 1);
         end
      end
      chk("timeout_error", error, 1);
      chk("timeout_busy", busy, 0);
      @(posedge clk); #1 abort = 1'b1;
      @(negedge clk);
      chk("error_sticky_during_abort", error, 1);
      @(posedge clk); #1 abort = 1'b0;
      @(negedge clk);
      chk("abort_clears_error", error, 0);

      // Abort in the middle of the query stream.
      run_image(1'b1, 1'b0, 2, 100, 0, 4000);
      @(posedge clk); #1 abort = 1'b1;
      @(negedge clk);
      chk("abort_src_ready", src_ready, 0);
      chk("abort_wenq", in_fifo_wenq, 0);
      chk("abort_busy_same_cycle", busy, 1);
      @(posedge clk); #1 abort = 1'b0;
      @(negedge clk);
      chk("abort_idle", busy, 0);

      // Asynchronous reset mid-drain, then a fresh image restarts addressing.
      run_image(1'b1, 1'b0, 2, 0, 50, 4000);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_res_valid", res_valid, 0);
      chk("arst_res_addr", res_addr, 0);
      chk("arst_res_data", res_data, 0);
      chk("arst_busy", busy, 0);
      chk("arst_deq", out_fifo_deq, 0);
      @(posedge clk); #1 rst_n = 1'b1;
      run_image(1'b1, 1'b0, 2, 0, 0, 4000);
      check_complete(1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
